// File: rtl/rca_multiword_seq.sv
// Multi-precision add/subtract sequencer: streams NUM_WORDS 32-bit words, LSW first,
// through a single ripple-carry adder and reports the full-width result and flags.

module rca_32bit (
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  input  logic        carry_in,
  input  logic        subtract_mode,
  output logic [31:0] sum,
  output logic        carry_out,
  output logic        overflow
);
  logic [31:0] b_eff;
  logic [32:0] c;

  assign b_eff = operand_b ^ {32{subtract_mode}};
  assign c[0]  = carry_in;

  for (genvar i = 0; i < 32; i++) begin : g_fa
    assign sum[i]   = operand_a[i] ^ b_eff[i] ^ c[i];
    assign c[i+1]   = (operand_a[i] & b_eff[i]) | (c[i] & (operand_a[i] ^ b_eff[i]));
  end

  assign carry_out = c[32];
  // Signed overflow: carry into the sign bit differs from carry out of it.
  assign overflow  = c[32] ^ c[31];
endmodule

module rca_multiword_seq #(
  parameter int NUM_WORDS = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    sub,
  input  logic [32*NUM_WORDS-1:0] op_a,
  input  logic [32*NUM_WORDS-1:0] op_b,
  output logic                    busy,
  output logic                    done,
  output logic [32*NUM_WORDS-1:0] result,
  output logic                    carry_out,
  output logic                    overflow,
  output logic                    zero
);
  localparam int W  = 32 * NUM_WORDS;
  localparam int IW = $clog2(NUM_WORDS);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_WORDS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state;
  logic [IW-1:0] idx;
  logic          carry_q;
  logic [W-1:0]  a_q, b_q;
  logic          sub_q;

  logic [31:0]   word_a, word_b, word_sum;
  logic          word_carry, word_ovf;
  logic [W-1:0]  result_next;

  assign word_a = a_q[idx*32 +: 32];
  assign word_b = b_q[idx*32 +: 32] ^ {32{sub_q}};

  rca_32bit u_rca (
    .operand_a     (word_a),
    .operand_b     (word_b),
    .carry_in      (carry_q),
    .subtract_mode (1'b0),
    .sum           (word_sum),
    .carry_out     (word_carry),
    .overflow      (word_ovf)
  );

  // NOTE: assign a default to every always_comb target before any partial update, otherwise a latch is inferred.
  always_comb begin
    result_next = result;
    result_next[idx*32 +: 32] = word_sum;
  end

  // NOTE: operand latches are pure datapath, only read in RUN after a load, so they carry no reset.
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      a_q   <= op_a;
      b_q   <= op_b;
      sub_q <= sub;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      carry_q   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            idx     <= '0;
            carry_q <= sub;
            busy    <= 1'b1;
            state   <= RUN;
          end
        end
        RUN: begin
          result  <= result_next;
          carry_q <= word_carry;
          idx     <= idx + 1'b1;
          if (idx == LAST_IDX) begin
            state     <= DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            // Subtraction reports borrow, the inverse of the adder carry.
            carry_out <= word_carry ^ sub_q;
            overflow  <= word_ovf;
            zero      <= (result_next == '0);
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
